// File: rtl/umi_reg_endpoint.sv
// -----------------------------------------------------------------------------
// umi_reg_endpoint
//   UMI device-side endpoint that converts single-word UMI requests into a
//   simple register strobe interface. It handles one transaction at a time.
//   Register read data is expected one cycle after reg_read. Read and write
//   responses are generated back toward the host.
//
//   Optional build macro: UMI_REGIF_ERR_RESP_EN
//     When defined, two kinds of request get an error response (cmd[26:25]=2'b10,
//     data 0) and no register strobe:
//       - requests with an unsupported opcode
//       - READ or WRITE requests with a non-zero len
//     Normal responses carry cmd[26:25]=2'b00.
//     When undefined, unsupported opcodes are dropped silently, and cmd[26:25]
//     is copied from the request.
//
// Ports
//   clk, nreset            clock; asynchronous active-low reset
//   udev_req_*             UMI request channel (valid/ready handshake)
//   udev_resp_*            UMI response channel (valid/ready handshake)
//   reg_addr               register address (full request dstaddr)
//   reg_write / reg_read   one-cycle write / read strobes
//   reg_opcode/size/len    request cmd fields [4:0], [7:5], [15:8]
//   reg_wrdata             write data, request data[RW-1:0]
//   reg_rddata             read data, valid the cycle after reg_read
// -----------------------------------------------------------------------------
module umi_reg_endpoint #(
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256,
  parameter int RW = 32
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          udev_req_valid,
  input  logic [CW-1:0] udev_req_cmd,
  input  logic [AW-1:0] udev_req_dstaddr,
  input  logic [AW-1:0] udev_req_srcaddr,
  input  logic [DW-1:0] udev_req_data,
  output logic          udev_req_ready,
  output logic          udev_resp_valid,
  output logic [CW-1:0] udev_resp_cmd,
  output logic [AW-1:0] udev_resp_dstaddr,
  output logic [AW-1:0] udev_resp_srcaddr,
  output logic [DW-1:0] udev_resp_data,
  input  logic          udev_resp_ready,
  output logic [AW-1:0] reg_addr,
  output logic          reg_write,
  output logic          reg_read,
  output logic [4:0]    reg_opcode,
  output logic [2:0]    reg_size,
  output logic [7:0]    reg_len,
  output logic [RW-1:0] reg_wrdata,
  input  logic [RW-1:0] reg_rddata
);

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_r;
  logic          ready_r;
  logic [CW-1:0] cmd_r;
  logic [AW-1:0] dstaddr_r;
  logic [AW-1:0] srcaddr_r;
  logic [RW-1:0] wrdata_r;
  logic          err_r;
  logic          reg_read_r;
  logic          reg_write_r;
  logic          resp_valid_r;
  logic [CW-1:0] resp_cmd_r;
  logic [DW-1:0] resp_data_r;

  logic          hs_s;
  logic          is_read_s;
  logic          is_write_s;
  logic          is_posted_s;
  logic          err_s;
  logic          unused_s;

  // Build the response command.
  // The upper command bits are copied from the request.
  // In error-response builds, bits [26:25] carry the response status.
  function automatic logic [CW-1:0] resp_cmd_f(input logic [CW-1:0] req_cmd,
                                               input logic [4:0]    op,
                                               input logic          err);
    logic [CW-1:0] res;
    res = {req_cmd[CW-1:5], op};
`ifdef UMI_REGIF_ERR_RESP_EN
    res[26:25] = err ? 2'b10 : 2'b00;
`else
    res[26:25] = res[26:25] | {1'b0, err};
`endif
    return res;
  endfunction

  // Error responses to read-like opcodes come back as RESP_READ.
  // All other error responses come back as RESP_WRITE.
  function automatic logic [4:0] err_op_f(input logic [4:0] op);
    return (!op[2] && !op[1] && op[0]) ? RESP_READ : RESP_WRITE;
  endfunction

  assign hs_s     = udev_req_valid && ready_r;
  assign unused_s = ^udev_req_data;

  // Decode the incoming request opcode and decide whether it is an error.
  always_comb begin
    is_read_s   = (udev_req_cmd[4:0] == REQ_READ);
    is_write_s  = (udev_req_cmd[4:0] == REQ_WRITE);
    is_posted_s = (udev_req_cmd[4:0] == REQ_POSTED);
`ifdef UMI_REGIF_ERR_RESP_EN
    if (!(is_read_s || is_write_s || is_posted_s)) begin
      err_s = 1'b1;
    end else if ((is_read_s || is_write_s) && (udev_req_cmd[15:8] != 8'h00)) begin
      err_s = 1'b1;
    end else begin
      err_s = 1'b0;
    end
`else
    err_s = 1'b0;
`endif
  end

  // Transaction FSM.
  // Holds the request latches and drives every registered output.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r      <= IDLE;
      ready_r      <= 1'b0;
      cmd_r        <= {CW{1'b0}};
      dstaddr_r    <= {AW{1'b0}};
      srcaddr_r    <= {AW{1'b0}};
      wrdata_r     <= {RW{1'b0}};
      err_r        <= 1'b0;
      reg_read_r   <= 1'b0;
      reg_write_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_cmd_r   <= {CW{1'b0}};
      resp_data_r  <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (hs_s) begin
            cmd_r       <= udev_req_cmd;
            dstaddr_r   <= udev_req_dstaddr;
            srcaddr_r   <= udev_req_srcaddr;
            wrdata_r    <= udev_req_data[RW-1:0];
            err_r       <= err_s;
            // Strobes are registered here so that they are high during STROBE.
            reg_read_r  <= is_read_s && !err_s;
            reg_write_r <= (is_write_s || is_posted_s) && !err_s;
            ready_r     <= 1'b0;
            state_r     <= STROBE;
          end else begin
            // The first idle edge after reset raises ready.
            ready_r <= 1'b1;
          end
        end
        STROBE: begin
          reg_read_r  <= 1'b0;
          reg_write_r <= 1'b0;
          if (err_r) begin
            resp_cmd_r   <= resp_cmd_f(cmd_r, err_op_f(cmd_r[4:0]), 1'b1);
            resp_data_r  <= {DW{1'b0}};
            resp_valid_r <= 1'b1;
            state_r      <= RESP;
          end else begin
            case (cmd_r[4:0])
              REQ_READ: begin
                state_r <= RDWAIT;
              end
              REQ_WRITE: begin
                resp_cmd_r   <= resp_cmd_f(cmd_r, RESP_WRITE, 1'b0);
                resp_data_r  <= {DW{1'b0}};
                resp_valid_r <= 1'b1;
                state_r      <= RESP;
              end
              default: begin
                // Posted writes and dropped opcodes return straight to idle.
                ready_r <= 1'b1;
                state_r <= IDLE;
              end
            endcase
          end
        end
        RDWAIT: begin
          resp_cmd_r   <= resp_cmd_f(cmd_r, RESP_READ, 1'b0);
          resp_data_r  <= DW'(reg_rddata);
          resp_valid_r <= 1'b1;
          state_r      <= RESP;
        end
        RESP: begin
          if (udev_resp_ready) begin
            resp_valid_r <= 1'b0;
            ready_r      <= 1'b1;
            state_r      <= IDLE;
          end else begin
            resp_valid_r <= 1'b1;
          end
        end
        default: begin
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign udev_req_ready    = ready_r;
  assign udev_resp_valid   = resp_valid_r;
  assign udev_resp_cmd     = resp_cmd_r;
  assign udev_resp_dstaddr = srcaddr_r;
  assign udev_resp_srcaddr = dstaddr_r;
  assign udev_resp_data    = resp_data_r;
  assign reg_addr          = dstaddr_r;
  assign reg_write         = reg_write_r;
  assign reg_read          = reg_read_r;
  assign reg_opcode        = cmd_r[4:0];
  assign reg_size          = cmd_r[7:5];
  assign reg_len           = cmd_r[15:8];
  assign reg_wrdata        = wrdata_r;

endmodule

// File: tb/tb_umi_reg_endpoint.sv
// -----------------------------------------------------------------------------
// tb_umi_reg_endpoint
//   Self-checking bench for umi_reg_endpoint.
//   The bench uses directed cases plus randomized traffic.
//   Expected values come from a transaction-level reference memory and
//   from response rules written directly from the block's description.
//   A small register-bank stub behind the strobe interface supplies read data.
// -----------------------------------------------------------------------------
module tb_umi_reg_endpoint;

  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;
  localparam int RW = 32;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] REQ_POSTED = 5'h05;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  logic          clk = 1'b0;
  logic          nreset;
  logic          udev_req_valid;
  logic [CW-1:0] udev_req_cmd;
  logic [AW-1:0] udev_req_dstaddr;
  logic [AW-1:0] udev_req_srcaddr;
  logic [DW-1:0] udev_req_data;
  logic          udev_req_ready;
  logic          udev_resp_valid;
  logic [CW-1:0] udev_resp_cmd;
  logic [AW-1:0] udev_resp_dstaddr;
  logic [AW-1:0] udev_resp_srcaddr;
  logic [DW-1:0] udev_resp_data;
  logic          udev_resp_ready;
  logic [AW-1:0] reg_addr;
  logic          reg_write;
  logic          reg_read;
  logic [4:0]    reg_opcode;
  logic [2:0]    reg_size;
  logic [7:0]    reg_len;
  logic [RW-1:0] reg_wrdata;
  logic [RW-1:0] reg_rddata;

  int n_cmp = 0;
  int n_err = 0;
  int exp_wr = 0, exp_rd = 0, exp_resp = 0;
  int wr_cnt = 0, rd_cnt = 0, resp_cnt = 0;

  bit [31:0] bank [0:1023];
  bit [31:0] ref_mem [longint];

  always #5 clk = ~clk;

  umi_reg_endpoint #(.CW(CW), .AW(AW), .DW(DW), .RW(RW)) dut (
    .clk(clk), .nreset(nreset),
    .udev_req_valid(udev_req_valid), .udev_req_cmd(udev_req_cmd),
    .udev_req_dstaddr(udev_req_dstaddr), .udev_req_srcaddr(udev_req_srcaddr),
    .udev_req_data(udev_req_data), .udev_req_ready(udev_req_ready),
    .udev_resp_valid(udev_resp_valid), .udev_resp_cmd(udev_resp_cmd),
    .udev_resp_dstaddr(udev_resp_dstaddr), .udev_resp_srcaddr(udev_resp_srcaddr),
    .udev_resp_data(udev_resp_data), .udev_resp_ready(udev_resp_ready),
    .reg_addr(reg_addr), .reg_write(reg_write), .reg_read(reg_read),
    .reg_opcode(reg_opcode), .reg_size(reg_size), .reg_len(reg_len),
    .reg_wrdata(reg_wrdata), .reg_rddata(reg_rddata)
  );

  // Register bank stub: one-cycle read latency.
  always @(posedge clk) begin
    if (reg_write) bank[reg_addr[11:2]] <= reg_wrdata;
    if (reg_read)  reg_rddata <= bank[reg_addr[11:2]];
  end

  // Count the strobes and response handshakes that the DUT actually produces.
  always @(posedge clk) begin
    if (nreset) begin
      if (reg_write) wr_cnt <= wr_cnt + 1;
      if (reg_read)  rd_cnt <= rd_cnt + 1;
      if (udev_resp_valid && udev_resp_ready) resp_cnt <= resp_cnt + 1;
    end
  end

  task automatic check_value(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] ref_get(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic bit is_supported(input logic [4:0] op);
    return (op == REQ_READ) || (op == REQ_WRITE) || (op == REQ_POSTED);
  endfunction

  // Expected response command built from the request command.
  function automatic logic [CW-1:0] exp_cmd(input logic [CW-1:0] req, input logic [4:0] op, input bit err);
    logic [CW-1:0] r;
    r = {req[CW-1:5], op};
`ifdef UMI_REGIF_ERR_RESP_EN
    r[26:25] = err ? 2'b10 : 2'b00;
`endif
    return r;
  endfunction

  // Drive one request through its handshake.
  // Returns #1 after the handshake edge and checks the strobe cycle there.
  task automatic send_req(input logic [4:0] op, input logic [63:0] addr, input logic [31:0] data,
                          output logic [CW-1:0] cmd, output logic [AW-1:0] src);
    logic [7:0]    len;
    logic [DW-1:0] d;
    int            n;
    bit            ok;
    bit            wr_s, rd_s;
`ifdef UMI_REGIF_ERR_RESP_EN
    len = 8'h00;
`else
    len = 8'($urandom);
`endif
    cmd = {16'($urandom), len, 3'($urandom), op};
    src = {32'($urandom), 32'($urandom)};
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    d[31:0] = data;
    repeat ($urandom_range(0, 2)) @(negedge clk);
    @(negedge clk);
    udev_req_valid   = 1'b1;
    udev_req_cmd     = cmd;
    udev_req_dstaddr = addr;
    udev_req_srcaddr = src;
    udev_req_data    = d;
    n = 0;
    while (!udev_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    ok = udev_req_ready;
    if (!ok) begin
      check_value("req_timeout", 256'd0, 256'd1);
      udev_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    udev_req_valid = 1'b0;
    rd_s = (op == REQ_READ);
    wr_s = (op == REQ_WRITE) || (op == REQ_POSTED);
    check_value("strobe_read",  reg_read,  rd_s);
    check_value("strobe_write", reg_write, wr_s);
    check_value("reg_addr",     reg_addr,  addr);
    check_value("reg_opcode",   reg_opcode, op);
    check_value("reg_size",     reg_size,  cmd[7:5]);
    check_value("reg_len",      reg_len,   len);
    check_value("reg_wrdata",   reg_wrdata, data);
    if (wr_s) begin
      ref_mem[addr] = data;
      exp_wr++;
    end
    if (rd_s) exp_rd++;
  endtask

  // Wait for a response under random ready, then compare all its fields.
  task automatic expect_resp(input logic [CW-1:0] ecmd, input logic [AW-1:0] edst,
                             input logic [AW-1:0] esrc, input logic [DW-1:0] edata);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    exp_resp++;
    while (!done && n < 200) begin
      @(negedge clk);
      udev_resp_ready = ($urandom_range(0, 3) != 0);
      if (udev_resp_valid && udev_resp_ready) begin
        check_value("resp_cmd",     udev_resp_cmd,     ecmd);
        check_value("resp_dstaddr", udev_resp_dstaddr, edst);
        check_value("resp_srcaddr", udev_resp_srcaddr, esrc);
        check_value("resp_data",    udev_resp_data,    edata);
        done = 1'b1;
      end
      n++;
    end
    if (!done) check_value("resp_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
    udev_resp_ready = 1'b0;
  endtask

  // Check that no response appears, then check that the request side is ready again.
  task automatic expect_none(input int cycles);
    bit seen;
    seen = 1'b0;
    repeat (cycles) begin
      @(negedge clk);
      if (udev_resp_valid) seen = 1'b1;
    end
    check_value("no_resp", seen, 1'b0);
    check_value("ready_back", udev_req_ready, 1'b1);
  endtask

  task automatic do_txn(input logic [4:0] op, input logic [63:0] addr, input logic [31:0] data);
    logic [CW-1:0] cmd;
    logic [AW-1:0] src;
    send_req(op, addr, data, cmd, src);
    if (op == REQ_READ) begin
      expect_resp(exp_cmd(cmd, RESP_READ, 1'b0), src, addr, DW'(ref_get(addr)));
    end else if (op == REQ_WRITE) begin
      expect_resp(exp_cmd(cmd, RESP_WRITE, 1'b0), src, addr, {DW{1'b0}});
    end else if (op == REQ_POSTED) begin
      expect_none(4);
    end else begin
`ifdef UMI_REGIF_ERR_RESP_EN
      expect_resp(exp_cmd(cmd, (!op[2] && !op[1] && op[0]) ? RESP_READ : RESP_WRITE, 1'b1),
                  src, addr, {DW{1'b0}});
`else
      expect_none(4);
`endif
    end
  endtask

  initial begin
    logic [CW-1:0] cmd;
    logic [AW-1:0] src;
    logic [4:0]    op;
    bit            bad;
    int            n;

    nreset = 1'b0;
    udev_req_valid = 1'b0;
    udev_req_cmd = '0;
    udev_req_dstaddr = '0;
    udev_req_srcaddr = '0;
    udev_req_data = '0;
    udev_resp_ready = 1'b0;

    // Reset state.
    #12;
    check_value("rst_ready",      udev_req_ready,  1'b0);
    check_value("rst_resp_valid", udev_resp_valid, 1'b0);
    check_value("rst_strobes",    {reg_read, reg_write}, 2'b00);
    check_value("rst_reg_addr",   reg_addr,        64'h0);
    check_value("rst_resp_cmd",   udev_resp_cmd,   32'h0);
    check_value("rst_resp_data",  udev_resp_data,  {DW{1'b0}});
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1;
    check_value("ready_after_rst", udev_req_ready, 1'b1);

    // Write then read.
    do_txn(REQ_WRITE, 64'h10, 32'hDEADBEEF);
    do_txn(REQ_READ,  64'h10, 32'h0);

    // Latency with ready held high.
    send_req(REQ_WRITE, 64'h14, 32'h12345678, cmd, src);
    check_value("wr_lat_c1", udev_resp_valid, 1'b0);
    @(posedge clk); #1;
    check_value("wr_lat_c2", udev_resp_valid, 1'b1);
    expect_resp(exp_cmd(cmd, RESP_WRITE, 1'b0), src, 64'h14, {DW{1'b0}});
    send_req(REQ_READ, 64'h14, 32'h0, cmd, src);
    check_value("rd_lat_c1", udev_resp_valid, 1'b0);
    @(posedge clk); #1;
    check_value("rd_lat_c2", udev_resp_valid, 1'b0);
    @(posedge clk); #1;
    check_value("rd_lat_c3", udev_resp_valid, 1'b1);
    expect_resp(exp_cmd(cmd, RESP_READ, 1'b0), src, 64'h14, DW'(ref_get(64'h14)));

    // Backpressure: response fields stay stable, no new request accepted, no strobes.
    send_req(REQ_WRITE, 64'h18, 32'hA5A5F00D, cmd, src);
    udev_resp_ready = 1'b0;
    n = 0;
    while (!udev_resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (!udev_resp_valid || udev_req_ready || reg_write || reg_read) bad = 1'b1;
      if (udev_resp_cmd !== exp_cmd(cmd, RESP_WRITE, 1'b0)) bad = 1'b1;
      if (udev_resp_dstaddr !== src || udev_resp_srcaddr !== 64'h18) bad = 1'b1;
      if (udev_resp_data !== {DW{1'b0}}) bad = 1'b1;
    end
    check_value("backpressure_hold", bad, 1'b0);
    expect_resp(exp_cmd(cmd, RESP_WRITE, 1'b0), src, 64'h18, {DW{1'b0}});

    // Posted write followed by a readback.
    do_txn(REQ_POSTED, 64'h20, 32'h55AA55AA);
    do_txn(REQ_READ,   64'h20, 32'h0);

    // Unsupported opcode.
    do_txn(5'h07, 64'h24, 32'hCAFEBABE);
    do_txn(REQ_READ, 64'h24, 32'h0);

    // Randomized traffic over 512 word addresses.
    for (int i = 0; i < 600; i++) begin
      n = $urandom_range(0, 9);
      if (n < 4)      op = REQ_WRITE;
      else if (n < 8) op = REQ_READ;
      else if (n < 9) op = REQ_POSTED;
      else begin
        op = 5'($urandom);
        while (is_supported(op)) op = 5'($urandom);
      end
      do_txn(op, 64'($urandom_range(0, 511) * 4), $urandom);
    end

    // Reset asserted during RDWAIT aborts the read.
    send_req(REQ_READ, 64'h40, 32'h0, cmd, src);
    @(posedge clk); #1;
    nreset = 1'b0;
    #1;
    check_value("mid_rst_resp_valid", udev_resp_valid, 1'b0);
    check_value("mid_rst_strobes",    {reg_read, reg_write}, 2'b00);
    check_value("mid_rst_ready",      udev_req_ready, 1'b0);
    check_value("mid_rst_reg_addr",   reg_addr, 64'h0);
    repeat (2) @(negedge clk);
    nreset = 1'b1;
    @(posedge clk); #1;
    check_value("post_rst_ready", udev_req_ready, 1'b1);
    udev_resp_ready = 1'b1;
    expect_none(6);
    udev_resp_ready = 1'b0;
    do_txn(REQ_READ, 64'h10, 32'h0);

    repeat (3) @(negedge clk);
    check_value("write_strobes", wr_cnt,   exp_wr);
    check_value("read_strobes",  rd_cnt,   exp_rd);
    check_value("resp_count",    resp_cnt, exp_resp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
